// File: rtl/valu_seq.sv
// ============================================================================
// Module   : valu_seq
// Purpose  : Sequential vector ALU, one element per clock (add/sub/smul/dot).
//            Optional signed saturation with sticky sat_o when VALU_SAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module valu_seq #(
    parameter int ELEN = 32,
    parameter int VLEN = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           VALUCtrl_i,
    input  logic [ELEN*VLEN-1:0] vs1_i,
    input  logic [ELEN*VLEN-1:0] vs2_i,
    input  logic [ELEN-1:0]      rs1_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ELEN*VLEN-1:0] vd_o,
    output logic [ELEN-1:0]      sd_o
`ifdef VALU_SAT_EN
    ,
    output logic                 sat_o
`endif
);

    localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(VLEN - 1);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_DOT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [2:0]            op;
    logic [ELEN*VLEN-1:0]  a_q;
    logic [ELEN*VLEN-1:0]  b_q;
    logic [ELEN-1:0]       rs_q;

    logic [ELEN-1:0]       ea;
    logic [ELEN-1:0]       eb;
    logic [ELEN-1:0]       elem;
    logic [ELEN-1:0]       acc_next;

`ifdef VALU_SAT_EN
    localparam logic [ELEN-1:0] SMAX = {1'b0, {(ELEN-1){1'b1}}};
    localparam logic [ELEN-1:0] SMIN = {1'b1, {(ELEN-1){1'b0}}};

    logic            elem_sat;
    logic            prod_sat;
    logic            acc_sat;
    logic [ELEN-1:0] prod;

    // Returns {overflow, clamped result}; a sign-extended extra bit exposes overflow.
    function automatic logic [ELEN:0] sat_addsub(input logic [ELEN-1:0] x,
                                                 input logic [ELEN-1:0] y,
                                                 input logic            sub);
        logic [ELEN:0] s;
        s = sub ? ({x[ELEN-1], x} - {y[ELEN-1], y})
                : ({x[ELEN-1], x} + {y[ELEN-1], y});
        if (s[ELEN] != s[ELEN-1])
            return {1'b1, (s[ELEN] ? SMIN : SMAX)};
        return {1'b0, s[ELEN-1:0]};
    endfunction

    function automatic logic [ELEN:0] sat_mul(input logic [ELEN-1:0] x,
                                              input logic [ELEN-1:0] y);
        logic signed [2*ELEN-1:0] p;
        p = $signed(x) * $signed(y);
        if (p[2*ELEN-1:ELEN-1] == {(ELEN+1){p[2*ELEN-1]}})
            return {1'b0, p[ELEN-1:0]};
        return {1'b1, (p[2*ELEN-1] ? SMIN : SMAX)};
    endfunction
`endif

    always_comb begin
        ea       = a_q[idx*ELEN +: ELEN];
        eb       = b_q[idx*ELEN +: ELEN];
        elem     = '0;
        acc_next = sd_o;
`ifdef VALU_SAT_EN
        elem_sat = 1'b0;
        prod_sat = 1'b0;
        acc_sat  = 1'b0;
        prod     = '0;
        case (op)
            OP_ADD: {elem_sat, elem} = sat_addsub(ea, eb, 1'b0);
            OP_SUB: {elem_sat, elem} = sat_addsub(ea, eb, 1'b1);
            OP_MUL: {elem_sat, elem} = sat_mul(ea, rs_q);
            OP_DOT: begin
                {prod_sat, prod}    = sat_mul(ea, eb);
                {acc_sat, acc_next} = sat_addsub(sd_o, prod, 1'b0);
                elem_sat            = prod_sat | acc_sat;
            end
            default: ;
        endcase
`else
        case (op)
            OP_ADD:  elem     = ea + eb;
            OP_SUB:  elem     = ea - eb;
            OP_MUL:  elem     = ea * rs_q;
            OP_DOT:  acc_next = sd_o + ea * eb;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            idx    <= '0;
            op     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rs_q   <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            vd_o   <= '0;
            sd_o   <= '0;
`ifdef VALU_SAT_EN
            sat_o  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op     <= VALUCtrl_i;
                        a_q    <= vs1_i;
                        b_q    <= vs2_i;
                        rs_q   <= rs1_i;
                        vd_o   <= '0;
                        sd_o   <= '0;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
`ifdef VALU_SAT_EN
                        sat_o  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // elem is zero for dot and unlisted codes, so vd_o stays cleared
                    vd_o[idx*ELEN +: ELEN] <= elem;
                    sd_o                   <= acc_next;
`ifdef VALU_SAT_EN
                    sat_o                  <= sat_o | elem_sat;
`endif
                    if (idx == LAST) begin
                        idx    <= '0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
